tmds_lane_serializer: RTL and testbench

Single TMDS lane for the HDMI/DVI transmitter. It encodes one 8-bit pixel component (DE=1) or a 2-bit control symbol (DE=0) into a DC-balanced 10-bit TMDS word and shifts it out one bit per clock, LSB first, on a true/complement pair. It also generates the lane-aligned pixel-clock pattern used for the TMDS clock channel. One instance is used per colour channel; the clock lane uses the `tmdsClockOut` of any instance.

---
 rtl/tmds_lane_serializer.sv | 125 ++++++++++++
 tb/tb_tmds_lane_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_lane_serializer.sv
// Single TMDS lane for an HDMI/DVI transmitter.
// The lane encodes either a pixel byte or a control symbol into a
// DC-balanced 10-bit word. It shifts the word out LSB first on a
// true/complement pair. It also produces the lane-aligned pixel-clock
// pattern for the TMDS clock channel.
module tmds_lane_serializer (
  input  logic       serialClock,
  input  logic       resetN,
  input  logic [7:0] pixelComponent,
  input  logic [1:0] controlBus,
  input  logic       DE,
  output logic       pixelTick,
  output logic       tmdsSerialOut,
  output logic       tmdsSerialOutN,
  output logic       tmdsClockOut
);

  localparam logic [9:0] CTL_00 = 10'b1101010100;
  localparam logic [9:0] CTL_01 = 10'b0010101011;
  localparam logic [9:0] CTL_10 = 10'b0101010100;
  localparam logic [9:0] CTL_11 = 10'b1010101011;

  logic [3:0]        phase;
  logic              load;
  logic [9:0]        shift_reg;
  logic [9:0]        word_reg;
  logic signed [4:0] cnt;

  logic [3:0]        n1_d;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic [3:0]        n1_q;
  logic [3:0]        n0_q;
  logic signed [4:0] diff_q;
  logic [9:0]        q_out;
  logic signed [4:0] cnt_next;

  // The final bit period of each word; the next rising edge is the load edge.
  assign load = (phase == 4'd9);

  // Advance the bit phase 0..9. Every word boundary is derived from this counter.
  always_ff @(posedge serialClock or negedge resetN) begin
    if (!resetN) begin
      phase <= 4'd0;
    end else if (load) begin
      // NOTE: Use non-blocking assignments for every register. All flops then
      // sample values from before the edge, whatever order the blocks run in.
      phase <= 4'd0;
    end else begin
      phase <= phase + 4'd1;
    end
  end

  // Stage 1: choose XOR or XNOR chaining to minimise transitions in q_m[7:0].
  always_comb begin
    logic acc;
    // NOTE: Give every combinational output a value before any branch.
    // A path that leaves one unassigned would infer a latch.
    n1_d     = '0;
    q_m      = '0;
    acc      = pixelComponent[0];
    for (int i = 0; i < 8; i++) begin
      n1_d = n1_d + {3'b000, pixelComponent[i]};
    end
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !pixelComponent[0]);
    q_m[0]   = acc;
    for (int i = 1; i < 8; i++) begin
      acc    = acc ^ pixelComponent[i] ^ use_xnor;
      q_m[i] = acc;
    end
    q_m[8]   = !use_xnor;
  end

  // Stage 2: DC balance against the running disparity, or emit a control symbol.
  always_comb begin
    n1_q = '0;
    for (int i = 0; i < 8; i++) begin
      n1_q = n1_q + {3'b000, q_m[i]};
    end
    n0_q     = 4'd8 - n1_q;
    diff_q   = $signed(5'(n1_q) - 5'(n0_q));
    q_out    = CTL_00;
    cnt_next = cnt;
    if (!DE) begin
      unique case (controlBus)
        2'b00: q_out = CTL_00;
        2'b01: q_out = CTL_01;
        2'b10: q_out = CTL_10;
        2'b11: q_out = CTL_11;
      endcase
      cnt_next = 5'sd0;
    end else if ((cnt == 5'sd0) || (n1_q == n0_q)) begin
      q_out    = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? diff_q : -diff_q);
    end else if (((cnt > 5'sd0) && (n1_q > n0_q)) || ((cnt < 5'sd0) && (n0_q > n1_q))) begin
      q_out    = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff_q;
    end else begin
      q_out    = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt - (q_m[8] ? 5'sd0 : 5'sd2) + diff_q;
    end
  end

  // Load edges move the encoded word through a one-word pipeline.
  // All other edges shift the serializer right with zero fill.
  always_ff @(posedge serialClock or negedge resetN) begin
    if (!resetN) begin
      shift_reg <= '0;
      word_reg  <= CTL_00;
      cnt       <= 5'sd0;
    end else if (load) begin
      shift_reg <= word_reg;
      word_reg  <= q_out;
      cnt       <= cnt_next;
    end else begin
      shift_reg <= {1'b0, shift_reg[9:1]};
    end
  end

  assign pixelTick      = load;
  assign tmdsSerialOut  = shift_reg[0];
  assign tmdsSerialOutN = ~shift_reg[0];
  assign tmdsClockOut   = (phase < 4'd5);

endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Randomised, scoreboarded bench for tmds_lane_serializer.
// The driver pushes the expected word for each load edge.
// A negedge monitor rebuilds serial words, pops and compares them.
// It also checks decode, DC balance, the clock pattern and reset values.
module tb_tmds_lane_serializer;

  logic       serialClock = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] pixelComponent = '0;
  logic [1:0] controlBus = '0;
  logic       DE = 1'b0;
  logic       pixelTick;
  logic       tmdsSerialOut;
  logic       tmdsSerialOutN;
  logic       tmdsClockOut;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  typedef struct packed {
    logic       is_ctl;
    logic [7:0] data;
    logic [9:0] word;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt = 0;
  int          running = 0;
  int unsigned edges = 0;
  logic [9:0]  cur = '0;

  tmds_lane_serializer dut (
    .serialClock    (serialClock),
    .resetN         (resetN),
    .pixelComponent (pixelComponent),
    .controlBus     (controlBus),
    .DE             (DE),
    .pixelTick      (pixelTick),
    .tmdsSerialOut  (tmdsSerialOut),
    .tmdsSerialOutN (tmdsSerialOutN),
    .tmdsClockOut   (tmdsClockOut)
  );

  always #5 serialClock = ~serialClock;

  // Count rising edges since reset release; the word bit index is edges % 10.
  always @(posedge serialClock or negedge resetN) begin
    if (!resetN) edges <= 0;
    else         edges <= edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int disparity(input logic [9:0] w);
    return 2 * $countones(w) - 10;
  endfunction

  // Reference encoder. The running disparity is the ones-minus-zeros
  // total of every data word sent since the last control word.
  function automatic logic [9:0] model_encode(input logic de, input logic [1:0] c, input logic [7:0] d);
    logic [9:0] w;
    logic [7:0] qm;
    logic       qm8;
    int         ones_d;
    int         bias;
    if (!de) begin
      case (c)
        2'b00:   w = C00;
        2'b01:   w = C01;
        2'b10:   w = C10;
        default: w = C11;
      endcase
      m_cnt = 0;
      return w;
    end
    ones_d = $countones(d);
    qm8    = !((ones_d > 4) || (ones_d == 4 && d[0] == 1'b0));
    qm[0]  = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm8 ? (qm[i-1] ^ d[i]) : !(qm[i-1] ^ d[i]);
    bias = 2 * $countones(qm) - 8;
    if (m_cnt == 0 || bias == 0)        w = {~qm8, qm8, qm8 ? qm : ~qm};
    else if ((m_cnt > 0) == (bias > 0)) w = {1'b1, qm8, ~qm};
    else                                w = {1'b0, qm8, qm};
    m_cnt += disparity(w);
    return w;
  endfunction

  // Standard TMDS data decoder, used to confirm round-trip of every pixel.
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (b[i] ^ b[i-1]) : !(b[i] ^ b[i-1]);
    return d;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge serialClock) begin
    int   ph;
    logic exp_n;
    exp_t e;
    exp_n = ~tmdsSerialOut;
    check("complement", tmdsSerialOutN, exp_n);
    if (!resetN) begin
      check("rst_serial", tmdsSerialOut, 1'b0);
      check("rst_clock", tmdsClockOut, 1'b1);
      check("rst_tick", pixelTick, 1'b0);
      running = 0;
    end else begin
      ph = int'(edges % 10);
      check("tick", pixelTick, ph == 9);
      check("clock_pattern", tmdsClockOut, ph < 5);
      if (edges < 10) begin
        check("pre_load_zero", tmdsSerialOut, 1'b0);
      end else begin
        cur[ph] = tmdsSerialOut;
        if (ph == 9) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected actual=%b expected=none at %0t", cur, $time);
          end else begin
            e = sb_q.pop_front();
            check("word", cur, e.word);
            if (e.is_ctl) begin
              running = 0;
            end else begin
              running += disparity(cur);
              check("dc_bound", (running <= 20) && (running >= -20), 1'b1);
              check("decode", tmds_decode(cur), e.data);
            end
          end
        end
      end
    end
  end

  // Drive one word's inputs; only the value present at the load edge is real.
  task automatic send(input logic de, input logic [1:0] c, input logic [7:0] d,
                      input logic lit_en, input logic [9:0] lit);
    exp_t       e;
    logic [9:0] w;
    for (int i = 0; i < 9; i++) begin
      {DE, controlBus, pixelComponent} = 11'($urandom);
      @(negedge serialClock);
    end
    DE             = de;
    controlBus     = c;
    pixelComponent = d;
    w        = model_encode(de, c, d);
    e.word   = lit_en ? lit : w;
    e.is_ctl = !de;
    e.data   = d;
    sb_q.push_back(e);
    @(negedge serialClock);
  endtask

  task automatic release_reset();
    exp_t e;
    #2 resetN = 1'b1;
    sb_q.delete();
    e.word   = C00;
    e.is_ctl = 1'b1;
    e.data   = '0;
    sb_q.push_back(e);
    m_cnt = 0;
  endtask

  task automatic send_mixed(input int n);
    logic de;
    for (int i = 0; i < n; i++) begin
      de = ($urandom_range(0, 7) != 0);
      send(de, 2'($urandom), 8'($urandom), 1'b0, '0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int t;
    resetN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {DE, controlBus, pixelComponent} = 11'($urandom);
      @(negedge serialClock);
    end
    release_reset();

    send(1'b0, 2'b00, 8'h00, 1'b1, C00);
    send(1'b0, 2'b01, 8'h00, 1'b1, C01);
    send(1'b0, 2'b10, 8'h00, 1'b1, C10);
    send(1'b0, 2'b11, 8'h00, 1'b1, C11);
    send(1'b0, 2'b00, 8'h00, 1'b1, C00);
    send(1'b1, 2'b00, 8'h00, 1'b1, 10'b0100000000);
    send(1'b1, 2'b00, 8'h00, 1'b1, 10'b1111111111);
    send(1'b1, 2'b00, 8'h00, 1'b1, 10'b0100000000);
    send(1'b0, 2'b00, 8'h00, 1'b1, C00);
    send(1'b1, 2'b00, 8'hFF, 1'b1, 10'b1000000000);
    send(1'b0, 2'b00, 8'h00, 1'b1, C00);
    send(1'b1, 2'b00, 8'h00, 1'b1, 10'b0100000000);

    send(1'b0, 2'b01, 8'h00, 1'b0, '0);
    for (int i = 0; i < 2000; i++) send(1'b1, 2'b00, 8'($urandom), 1'b0, '0);
    send_mixed(300);

    repeat (4) @(negedge serialClock);
    #2 resetN = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_serial", tmdsSerialOut, 1'b0);
    check("mid_rst_serial_n", tmdsSerialOutN, 1'b1);
    check("mid_rst_clock", tmdsClockOut, 1'b1);
    check("mid_rst_tick", pixelTick, 1'b0);
    for (int i = 0; i < 3; i++) begin
      {DE, controlBus, pixelComponent} = 11'($urandom);
      @(negedge serialClock);
    end
    release_reset();
    send_mixed(20);

    t = 0;
    while (sb_q.size() > 0 && t < 100) begin
      @(negedge serialClock);
      t++;
    end
    check("drain", sb_q.size(), 0);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
